register_file_mp: RTL and testbench

- Parametrised multi-port successor to the single-write, two-read MIPS register file.
- Two write ports, three read ports, optional hardwired-zero register and optional same-cycle write-to-read bypass.
- Self-clearing reset sequencer with a ready flag, plus a registered write-collision flag.
- Sits in the decode stage: reads rs/rt/rd-store operands; writes from the WB and the late-load port.

---
 rtl/register_file_mp_if.sv | 35 +++
 rtl/register_file_mp.sv | 97 +++++++++
 tb/tb_register_file_mp.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-port register file: two write ports, three read
// ports, the ready flag and the registered write-collision pulse.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  ready;
  logic                  write0;
  logic [ADDR_WIDTH-1:0] write_reg0;
  logic [DATA_WIDTH-1:0] write_data0;
  logic                  write1;
  logic [ADDR_WIDTH-1:0] write_reg1;
  logic [DATA_WIDTH-1:0] write_data1;
  logic [ADDR_WIDTH-1:0] read_reg_0;
  logic [ADDR_WIDTH-1:0] read_reg_1;
  logic [ADDR_WIDTH-1:0] read_reg_2;
  logic [DATA_WIDTH-1:0] reg0;
  logic [DATA_WIDTH-1:0] reg1;
  logic [DATA_WIDTH-1:0] reg2;
  logic                  write_conflict;

  modport master (
    input  ready, reg0, reg1, reg2, write_conflict,
    output write0, write_reg0, write_data0,
           write1, write_reg1, write_data1,
           read_reg_0, read_reg_1, read_reg_2
  );

  modport slave (
    output ready, reg0, reg1, reg2, write_conflict,
    input  write0, write_reg0, write_data0,
           write1, write_reg1, write_data1,
           read_reg_0, read_reg_1, read_reg_2
  );
endinterface

// File: rtl/register_file_mp.sv
// Decode-stage register file: two write ports (port 1 wins), three combinational
// read ports, optional zero register and write bypass, self-clearing after reset.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic              cclk,
  input logic              rst,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clearCnt_q, clearCnt_d;
  logic                  conflict_q, conflict_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  running;
  logic                  writeEn0, writeEn1;
  logic [ADDR_WIDTH-1:0] readAddr [3];
  logic [DATA_WIDTH-1:0] readData [3];

  // A write to index 0 is discarded entirely when it is the hardwired zero.
  assign running  = (state_q == RUN);
  assign writeEn0 = running && bus.write0 && !((ZERO_REG != 0) && (bus.write_reg0 == '0));
  assign writeEn1 = running && bus.write1 && !((ZERO_REG != 0) && (bus.write_reg1 == '0));

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q    <= INIT;
      clearCnt_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clearCnt_q <= clearCnt_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clearCnt_d = clearCnt_q;
    conflict_d = 1'b0;
    case (state_q)
      INIT: begin
        clearCnt_d = clearCnt_q + 1'b1;
        if (clearCnt_q == '1) state_d = RUN;
      end
      RUN: begin
        conflict_d = bus.write0 && bus.write1 && (bus.write_reg0 == bus.write_reg1) &&
                     !((ZERO_REG != 0) && (bus.write_reg0 == '0));
      end
      default: state_d = INIT;
    endcase
  end

  // Port 1 is written last so it owns the entry when both ports hit one index.
  always_ff @(posedge cclk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem_q[clearCnt_q] <= '0;
      end else begin
        if (writeEn0) mem_q[bus.write_reg0] <= bus.write_data0;
        if (writeEn1) mem_q[bus.write_reg1] <= bus.write_data1;
      end
    end
  end

  assign readAddr[0] = bus.read_reg_0;
  assign readAddr[1] = bus.read_reg_1;
  assign readAddr[2] = bus.read_reg_2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      readData[i] = '0;
      if (running && !((ZERO_REG != 0) && (readAddr[i] == '0))) begin
        if ((BYPASS != 0) && writeEn1 && (readAddr[i] == bus.write_reg1)) begin
          readData[i] = bus.write_data1;
        end else if ((BYPASS != 0) && writeEn0 && (readAddr[i] == bus.write_reg0)) begin
          readData[i] = bus.write_data0;
        end else begin
          readData[i] = mem_q[readAddr[i]];
        end
      end
    end
  end

  assign bus.reg0           = readData[0];
  assign bus.reg1           = readData[1];
  assign bus.reg2           = readData[2];
  assign bus.ready          = running;
  assign bus.write_conflict = conflict_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default instance (zero reg + bypass) and a plain
// instance (no zero reg, no bypass) share stimulus and are checked against a model.
module tb_register_file_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic cclk;
  logic rst;
  logic          write0, write1;
  logic [AW-1:0] write_reg0, write_reg1;
  logic [DW-1:0] write_data0, write_data1;
  logic [AW-1:0] read_reg_0, read_reg_1, read_reg_2;

  int nCompared;
  int nMismatched;

  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busA ();
  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busB ();

  assign busA.write0 = write0;       assign busB.write0 = write0;
  assign busA.write_reg0 = write_reg0; assign busB.write_reg0 = write_reg0;
  assign busA.write_data0 = write_data0; assign busB.write_data0 = write_data0;
  assign busA.write1 = write1;       assign busB.write1 = write1;
  assign busA.write_reg1 = write_reg1; assign busB.write_reg1 = write_reg1;
  assign busA.write_data1 = write_data1; assign busB.write_data1 = write_data1;
  assign busA.read_reg_0 = read_reg_0; assign busB.read_reg_0 = read_reg_0;
  assign busA.read_reg_1 = read_reg_1; assign busB.read_reg_1 = read_reg_1;
  assign busA.read_reg_2 = read_reg_2; assign busB.read_reg_2 = read_reg_2;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dutA (
    .cclk(cclk), .rst(rst), .bus(busA.slave)
  );

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(0)) dutB (
    .cclk(cclk), .rst(rst), .bus(busB.slave)
  );

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  // Reference model: index 0 is instance A, index 1 is instance B.
  logic [DW-1:0] refMem [2][DEPTH];
  logic          refConf [2];
  int            refEdges;
  bit            hasZero [2] = '{1'b1, 1'b0};
  bit            hasByp  [2] = '{1'b1, 1'b0};

  function automatic bit refRunning();
    return refEdges >= DEPTH;
  endfunction

  function automatic bit portKept(int d, logic en, logic [AW-1:0] a);
    return en && !(hasZero[d] && a == 0);
  endfunction

  function automatic logic [DW-1:0] expRead(int d, logic [AW-1:0] a);
    if (!refRunning()) return '0;
    if (hasZero[d] && a == 0) return '0;
    if (hasByp[d] && portKept(d, write1, write_reg1) && a == write_reg1) return write_data1;
    if (hasByp[d] && portKept(d, write0, write_reg0) && a == write_reg0) return write_data0;
    return refMem[d][a];
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("A.ready", {31'b0, busA.ready}, {31'b0, refRunning()});
    checkOutput("B.ready", {31'b0, busB.ready}, {31'b0, refRunning()});
    checkOutput("A.conflict", {31'b0, busA.write_conflict}, {31'b0, refConf[0]});
    checkOutput("B.conflict", {31'b0, busB.write_conflict}, {31'b0, refConf[1]});
    checkOutput("A.reg0", busA.reg0, expRead(0, read_reg_0));
    checkOutput("A.reg1", busA.reg1, expRead(0, read_reg_1));
    checkOutput("A.reg2", busA.reg2, expRead(0, read_reg_2));
    checkOutput("B.reg0", busB.reg0, expRead(1, read_reg_0));
    checkOutput("B.reg1", busB.reg1, expRead(1, read_reg_1));
    checkOutput("B.reg2", busB.reg2, expRead(1, read_reg_2));
  endtask

  // One rising edge: the model consumes the inputs seen at that edge.
  task automatic tick();
    bit wasRunning;
    wasRunning = refRunning();
    @(posedge cclk);
    if (rst) begin
      refEdges = 0;
      refConf  = '{1'b0, 1'b0};
    end else if (!wasRunning) begin
      refMem[0][refEdges] = '0;
      refMem[1][refEdges] = '0;
      refEdges++;
      refConf = '{1'b0, 1'b0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        refConf[d] = write0 && write1 && write_reg0 == write_reg1 &&
                     !(hasZero[d] && write_reg0 == 0);
        if (portKept(d, write0, write_reg0)) refMem[d][write_reg0] = write_data0;
        if (portKept(d, write1, write_reg1)) refMem[d][write_reg1] = write_data1;
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                               input logic [AW-1:0] r2);
    write0 = w0; write_reg0 = a0; write_data0 = d0;
    write1 = w1; write_reg1 = a1; write_data1 = d1;
    read_reg_0 = r0; read_reg_1 = r1; read_reg_2 = r2;
    #1;
    checkAll();
  endtask

  task automatic idleCycle(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                           input logic [AW-1:0] r2);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, r0, r1, r2);
    tick();
  endtask

  task automatic waitReady();
    int budget;
    budget = 0;
    while (!refRunning() && budget < 100) begin
      idleCycle(5'(budget), 5'(budget + 1), 5'(budget + 2));
      budget++;
    end
  endtask

  logic [DW-1:0] basicVals [5] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8};

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    refEdges    = 0;
    refConf     = '{1'b0, 1'b0};
    for (int i = 0; i < DEPTH; i++) begin
      refMem[0][i] = '0;
      refMem[1][i] = '0;
    end
    rst = 1'b1;
    write0 = 0; write1 = 0; write_reg0 = 0; write_reg1 = 0;
    write_data0 = 0; write_data1 = 0;
    read_reg_0 = 0; read_reg_1 = 0; read_reg_2 = 0;
    tick();
    tick();
    #1;
    checkAll();
    rst = 1'b0;

    // Mid-init reset: reassert after 10 clearing edges, ready must restart the count.
    for (int i = 0; i < 10; i++) idleCycle(5'(i), 5'(i), 5'(i));
    rst = 1'b1;
    idleCycle(5'd1, 5'd2, 5'd3);
    rst = 1'b0;
    waitReady();
    checkAll();

    // Fill every entry with random data, then reset and confirm everything clears.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 5'(i), $urandom, 1'b0, '0, '0, 5'(i), 5'((i + 3) % DEPTH), 5'(DEPTH - 1 - i));
      tick();
    end
    rst = 1'b1;
    idleCycle(5'd4, 5'd5, 5'd6);
    rst = 1'b0;
    waitReady();
    for (int i = 0; i < DEPTH; i++) idleCycle(5'(i), 5'((i + 11) % DEPTH), 5'((i + 22) % DEPTH));

    // Zero register: a write to 0, then both ports aimed at 0.
    applyStimulus(1'b1, 5'd0, 32'h1, 1'b0, '0, '0, 5'd0, 5'd0, 5'd0);
    tick();
    idleCycle(5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 5'd0, 5'd1, 5'd0);
    tick();
    idleCycle(5'd0, 5'd0, 5'd0);

    // Basic writes: 1..5 <- 1,2,3,5,8, then 30 <- 13 and 31 <- 21 together.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'(i + 1), basicVals[i], 1'b0, '0, '0, 5'd2, 5'd4, 5'd31);
      tick();
    end
    applyStimulus(1'b1, 5'd30, 32'd13, 1'b1, 5'd31, 32'd21, 5'd30, 5'd31, 5'd6);
    tick();
    idleCycle(5'd2, 5'd4, 5'd31);
    idleCycle(5'd6, 5'd30, 5'd1);

    // Collision on index 7: port 1 data must land, pulse lasts one cycle.
    applyStimulus(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 5'd7, 5'd7, 5'd7);
    tick();
    idleCycle(5'd7, 5'd7, 5'd7);
    idleCycle(5'd7, 5'd7, 5'd7);

    // Bypass on index 9, seen before the edge on A only.
    applyStimulus(1'b1, 5'd9, 32'h1234, 1'b0, '0, '0, 5'd9, 5'd0, 5'd9);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hDEAD, 5'd9, 5'd9, 5'd9);
    tick();
    idleCycle(5'd9, 5'd9, 5'd9);

    // Random traffic, narrow address window half the time to force collisions.
    for (int n = 0; n < 2000; n++) begin
      logic [AW-1:0] a0, a1, ra, rb, rc;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a0 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rb = 5'($urandom);
      rc = narrow ? a1 : 5'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom, ra, rb, rc);
      tick();
    end
    rst = 1'b0;
    waitReady();
    idleCycle(5'd1, 5'd2, 5'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
